time_adjust_ctrl: RTL and testbench



---
 rtl/clock_pkg.sv | 17 +
 rtl/mod_updown_cnt.sv | 37 +++
 rtl/time_adjust_ctrl.sv | 116 +++++++++++
 tb/tb_time_adjust_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared encodings and field geometry for the digital clock time-keeping path.
package clock_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SET_H = 2'd1,
        ST_SET_M = 2'd2,
        ST_SET_S = 2'd3
    } state_t;

    localparam int unsigned HOUR_W  = 5;
    localparam int unsigned MIN_W   = 6;
    localparam int unsigned SEC_W   = 6;
    localparam int unsigned SEC_MOD = 60;
    localparam int unsigned MIN_MOD = 60;

endpackage

// File: rtl/mod_updown_cnt.sv
// Modulo-MOD up/down counter with parallel load; carry-out flags an up-step wrapping to zero.
module mod_updown_cnt #(
    parameter int unsigned W    = 6,
    parameter int unsigned MOD  = 60,
    parameter int unsigned INIT = 0
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         i_inc,
    input  logic         i_dec,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic [W-1:0] o_value,
    output logic         o_carry_c
);

    logic [W-1:0] r_value;
    logic         w_top;

    assign w_top     = (r_value == W'(MOD - 1));
    assign o_carry_c = i_inc & ~i_dec & ~i_load & w_top;
    assign o_value   = r_value;

    // Simultaneous inc and dec cancel out
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_value <= W'(INIT);
        end else if (i_load) begin
            r_value <= i_load_val;
        end else if (i_inc && !i_dec) begin
            r_value <= w_top ? '0 : r_value + W'(1);
        end else if (i_dec && !i_inc) begin
            r_value <= (r_value == '0) ? W'(MOD - 1) : r_value - W'(1);
        end
    end

endmodule

// File: rtl/time_adjust_ctrl.sv
// Authoritative hh:mm:ss keeper: run/set mode sequencing, key adjust, 1 Hz advance
// and serial time load, with load > mode > inc/dec > tick priority.
module time_adjust_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned HOUR_MOD = 24,
    parameter int unsigned INIT_H   = 0,
    parameter int unsigned INIT_M   = 0,
    parameter int unsigned INIT_S   = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              key_mode_p,
    input  logic              key_inc_p,
    input  logic              key_dec_p,
    input  logic              tick_1hz,
    input  logic              load_valid,
    input  logic [HOUR_W-1:0] load_h,
    input  logic [MIN_W-1:0]  load_m,
    input  logic [SEC_W-1:0]  load_s,
    output logic [HOUR_W-1:0] hour,
    output logic [MIN_W-1:0]  min,
    output logic [SEC_W-1:0]  sec,
    output logic [1:0]        edit_field,
    output logic              time_changed,
    output logic              load_err
);

    state_t r_state, w_state_nxt;
    logic   r_time_changed, r_load_err;
    logic   w_changed, w_err, w_load, w_load_ok, w_tick_run;
    logic   w_h_key_inc, w_h_dec, w_m_key_inc, w_m_dec, w_s_key_inc, w_s_dec;
    logic   w_h_inc, w_m_inc, w_s_inc;
    logic   w_sec_carry, w_min_carry, w_hour_carry_unused;

    assign w_load_ok = (load_h < HOUR_W'(HOUR_MOD)) && (load_m < MIN_W'(MIN_MOD))
                    && (load_s < SEC_W'(SEC_MOD));

    // Carries only ripple on a running tick, never during field editing
    assign w_s_inc = w_s_key_inc | w_tick_run;
    assign w_m_inc = w_m_key_inc | (w_tick_run & w_sec_carry);
    assign w_h_inc = w_h_key_inc | (w_tick_run & w_min_carry);

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_err       = 1'b0;
        w_changed   = 1'b0;
        w_tick_run  = 1'b0;
        w_h_key_inc = 1'b0;
        w_h_dec     = 1'b0;
        w_m_key_inc = 1'b0;
        w_m_dec     = 1'b0;
        w_s_key_inc = 1'b0;
        w_s_dec     = 1'b0;
        if (load_valid) begin
            if (w_load_ok) begin
                w_load      = 1'b1;
                w_state_nxt = ST_RUN;
                w_changed   = 1'b1;
            end else begin
                w_err = 1'b1;
            end
        end else if (key_mode_p) begin
            case (r_state)
                ST_RUN:   w_state_nxt = ST_SET_H;
                ST_SET_H: w_state_nxt = ST_SET_M;
                ST_SET_M: w_state_nxt = ST_SET_S;
                default:  w_state_nxt = ST_RUN;
            endcase
        end else if (key_inc_p || key_dec_p) begin
            w_changed = (r_state != ST_RUN) && (key_inc_p ^ key_dec_p);
            case (r_state)
                ST_SET_H: begin w_h_key_inc = key_inc_p; w_h_dec = key_dec_p; end
                ST_SET_M: begin w_m_key_inc = key_inc_p; w_m_dec = key_dec_p; end
                ST_SET_S: begin w_s_key_inc = key_inc_p; w_s_dec = key_dec_p; end
                default:  ;
            endcase
        end else if (tick_1hz && (r_state == ST_RUN)) begin
            w_tick_run = 1'b1;
            w_changed  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state        <= ST_RUN;
            r_time_changed <= 1'b0;
            r_load_err     <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_time_changed <= w_changed;
            r_load_err     <= w_err;
        end
    end

    mod_updown_cnt #(.W(SEC_W), .MOD(SEC_MOD), .INIT(INIT_S)) u_sec (
        .clk(clk), .rstn(rstn), .i_inc(w_s_inc), .i_dec(w_s_dec), .i_load(w_load),
        .i_load_val(load_s), .o_value(sec), .o_carry_c(w_sec_carry)
    );

    mod_updown_cnt #(.W(MIN_W), .MOD(MIN_MOD), .INIT(INIT_M)) u_min (
        .clk(clk), .rstn(rstn), .i_inc(w_m_inc), .i_dec(w_m_dec), .i_load(w_load),
        .i_load_val(load_m), .o_value(min), .o_carry_c(w_min_carry)
    );

    mod_updown_cnt #(.W(HOUR_W), .MOD(HOUR_MOD), .INIT(INIT_H)) u_hour (
        .clk(clk), .rstn(rstn), .i_inc(w_h_inc), .i_dec(w_h_dec), .i_load(w_load),
        .i_load_val(load_h), .o_value(hour), .o_carry_c(w_hour_carry_unused)
    );

    assign edit_field   = r_state;
    assign time_changed = r_time_changed;
    assign load_err     = r_load_err;

endmodule

// File: tb/tb_time_adjust_ctrl.sv
// Randomized scoreboard bench for time_adjust_ctrl against a seconds-of-day reference model.
module tb_time_adjust_ctrl;

    localparam int HM = 24;

    typedef struct packed {
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic [1:0] ef;
        logic       tc;
        logic       le;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic       key_mode_p, key_inc_p, key_dec_p, tick_1hz, load_valid;
    logic [4:0] load_h;
    logic [5:0] load_m, load_s;
    logic [4:0] hour, h12;
    logic [5:0] min, sec, m12, s12;
    logic [1:0] edit_field, ef12_unused;
    logic       time_changed, load_err, tc12_unused, le12_unused;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   m_h, m_m, m_s, m_st;

    always #5 clk = ~clk;

    time_adjust_ctrl dut (
        .clk(clk), .rstn(rstn), .key_mode_p(key_mode_p), .key_inc_p(key_inc_p),
        .key_dec_p(key_dec_p), .tick_1hz(tick_1hz), .load_valid(load_valid),
        .load_h(load_h), .load_m(load_m), .load_s(load_s), .hour(hour), .min(min),
        .sec(sec), .edit_field(edit_field), .time_changed(time_changed), .load_err(load_err)
    );

    time_adjust_ctrl #(.HOUR_MOD(12)) dut12 (
        .clk(clk), .rstn(rstn), .key_mode_p(key_mode_p), .key_inc_p(key_inc_p),
        .key_dec_p(key_dec_p), .tick_1hz(tick_1hz), .load_valid(load_valid),
        .load_h(load_h), .load_m(load_m), .load_s(load_s), .hour(h12), .min(m12),
        .sec(s12), .edit_field(ef12_unused), .time_changed(tc12_unused), .load_err(le12_unused)
    );

    // Monitor: each pushed expectation is due at the falling edge following its clock edge
    initial begin
        exp_t e, got;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                got = {hour, min, sec, edit_field, time_changed, load_err};
                n_total++;
                if (got == e) n_pass++;
                else $display("FAIL outputs t=%0t got %0d:%0d:%0d ef=%0d tc=%0b le=%0b exp %0d:%0d:%0d ef=%0d tc=%0b le=%0b",
                              $time, got.h, got.m, got.s, got.ef, got.tc, got.le,
                              e.h, e.m, e.s, e.ef, e.tc, e.le);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic model_reset();
        m_h = 0; m_m = 0; m_s = 0; m_st = 0;
    endtask

    task automatic step(input bit mode, input bit inc, input bit dec, input bit tick,
                        input bit lv, input int lh = 0, input int lm = 0, input int ls = 0);
        exp_t e;
        int   t, d;
        @(negedge clk);
        key_mode_p = mode; key_inc_p = inc; key_dec_p = dec; tick_1hz = tick;
        load_valid = lv; load_h = 5'(lh); load_m = 6'(lm); load_s = 6'(ls);
        e.tc = 1'b0;
        e.le = 1'b0;
        if (lv) begin
            if (lh < HM && lm < 60 && ls < 60) begin
                m_h = lh; m_m = lm; m_s = ls; m_st = 0; e.tc = 1'b1;
            end else begin
                e.le = 1'b1;
            end
        end else if (mode) begin
            m_st = (m_st + 1) % 4;
        end else if (inc || dec) begin
            if (m_st != 0 && inc != dec) begin
                d = inc ? 1 : -1;
                case (m_st)
                    1:       m_h = (m_h + d + HM) % HM;
                    2:       m_m = (m_m + d + 60) % 60;
                    default: m_s = (m_s + d + 60) % 60;
                endcase
                e.tc = 1'b1;
            end
        end else if (tick && m_st == 0) begin
            t   = (m_h * 3600 + m_m * 60 + m_s + 1) % (HM * 3600);
            m_h = t / 3600; m_m = (t / 60) % 60; m_s = t % 60;
            e.tc = 1'b1;
        end
        e.h = 5'(m_h); e.m = 6'(m_m); e.s = 6'(m_s); e.ef = 2'(m_st);
        @(posedge clk);
        #1;
        key_mode_p = 1'b0; key_inc_p = 1'b0; key_dec_p = 1'b0; tick_1hz = 1'b0; load_valid = 1'b0;
        q.push_back(e);
    endtask

    // Absolute expectations independent of the model
    task automatic chk_out(input string name, input int eh, input int em, input int es, input int eef);
        n_total++;
        if (hour == 5'(eh) && min == 6'(em) && sec == 6'(es) && edit_field == 2'(eef)) n_pass++;
        else $display("FAIL %s got %0d:%0d:%0d ef=%0d exp %0d:%0d:%0d ef=%0d",
                      name, hour, min, sec, edit_field, eh, em, es, eef);
    endtask

    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        #1;
        rstn = 1'b0;
        #1;
        n_total++;
        if (hour == 0 && min == 0 && sec == 0 && edit_field == 0 && !time_changed && !load_err) n_pass++;
        else $display("FAIL async_reset got %0d:%0d:%0d ef=%0d tc=%0b le=%0b exp 0:0:0 ef=0 tc=0 le=0",
                      hour, min, sec, edit_field, time_changed, load_err);
        model_reset();
        e = '0;
        @(posedge clk);
        #1;
        q.push_back(e);
        @(negedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        bit r_lv, r_md, r_inc, r_dec, r_tk;
        int r_h, r_m, r_s;
        rstn = 1'b0;
        key_mode_p = 1'b0; key_inc_p = 1'b0; key_dec_p = 1'b0; tick_1hz = 1'b0;
        load_valid = 1'b0; load_h = '0; load_m = '0; load_s = '0;
        model_reset();
        #1;
        chk_out("reset_state", 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;

        repeat (3) step(0, 0, 0, 1, 0);
        chk_out("three_ticks", 0, 0, 3, 0);

        step(0, 0, 0, 0, 1, 23, 59, 59);
        step(0, 0, 0, 1, 0);
        chk_out("day_wrap", 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 11, 59, 59);
        step(0, 0, 0, 1, 0);
        n_total++;
        if (h12 == 0 && m12 == 0 && s12 == 0) n_pass++;
        else $display("FAIL wrap_12h got %0d:%0d:%0d exp 0:0:0", h12, m12, s12);

        step(0, 0, 0, 0, 1, 10, 20, 30);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        repeat (21) step(0, 0, 1, 0, 0);
        repeat (3) step(0, 0, 0, 1, 0);
        chk_out("set_min_dec21", 10, 59, 30, 2);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        chk_out("tick_after_edit", 10, 59, 31, 0);

        step(0, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        chk_out("inc_dec_cancel", 0, 0, 0, 1);
        step(0, 0, 1, 0, 0);
        chk_out("hour_dec_wrap", 23, 0, 0, 1);

        step(0, 0, 0, 0, 1, 12, 61, 0);
        chk_out("load_reject", 23, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 8, 15, 45);
        chk_out("load_in_set_s", 8, 15, 45, 0);

        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        chk_out("mode_over_inc", 8, 15, 45, 2);
        do_reset();

        for (int i = 0; i < 1500; i++) begin
            r_lv  = ($urandom_range(0, 19) == 0);
            r_md  = ($urandom_range(0, 7) == 0);
            r_inc = ($urandom_range(0, 3) == 0);
            r_dec = ($urandom_range(0, 3) == 0);
            r_tk  = !r_inc && !r_dec && ($urandom_range(0, 2) != 0);
            r_h   = ($urandom_range(0, 3) == 0) ? 23 : int'($urandom_range(0, 27));
            r_m   = ($urandom_range(0, 2) == 0) ? 59 : int'($urandom_range(0, 63));
            r_s   = ($urandom_range(0, 2) == 0) ? 58 : int'($urandom_range(0, 63));
            step(r_md, r_inc, r_dec, r_tk, r_lv, r_h, r_m, r_s);
            if (i == 750) do_reset();
        end

        repeat (4) @(negedge clk);
        if (q.size() != 0) begin
            n_total++;
            $display("FAIL drain got %0d pending exp 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
